// File: rtl/count_run_scheduler.sv
// count_run_scheduler: round-robin owner of a shared LED count run.
// Optional RUN_ABORT_EN adds abort_btn / aborted (early end of a run).
module count_run_scheduler #(
  parameter int N_REQ     = 4,
  parameter int TICK_DIV  = 1500000,
  parameter int LED_W     = 4,
  parameter int MAX_COUNT = 15,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_btn,
  input  logic [N_REQ-1:0] req_btn,
`ifdef RUN_ABORT_EN
  input  logic             abort_btn,
  output logic             aborted,
`endif
  output logic [LED_W-1:0] led,
  output logic [N_REQ-1:0] grant,
  output logic [OW-1:0]    owner,
  output logic             busy,
  output logic             done_sig
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]    TMAX = CW'(TICK_DIV - 1);
  localparam logic [LED_W-1:0] LMAX = LED_W'(MAX_COUNT);
  localparam logic [OW-1:0]    OWN0 = OW'(N_REQ - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pend_nxt;
  logic [N_REQ-1:0] rq_s1, rq_s2, rq_s3;
  logic [N_REQ-1:0] rq_fall;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] clr;
  logic [OW-1:0]    win;
  logic             tick;

  // Two-flop synchronizer plus a delay flop for falling-edge detect
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      rq_s1 <= '1;
      rq_s2 <= '1;
      rq_s3 <= '1;
    end else begin
      rq_s1 <= req_btn;
      rq_s2 <= rq_s1;
      rq_s3 <= rq_s2;
    end
  end

  assign rq_fall = rq_s3 & ~rq_s2;

`ifdef RUN_ABORT_EN
  logic ab_s1, ab_s2, ab_s3;
  logic ab_fall;
  logic ab_flag;

  // Same conditioning for the abort button
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      ab_s1 <= 1'b1;
      ab_s2 <= 1'b1;
      ab_s3 <= 1'b1;
    end else begin
      ab_s1 <= abort_btn;
      ab_s2 <= ab_s1;
      ab_s3 <= ab_s2;
    end
  end

  assign ab_fall = ab_s3 & ~ab_s2;
  assign aborted = ab_flag;
`endif

  // Round-robin pick: nearest pending index after the last owner
  always_comb begin
    int idx;
    logic [OW-1:0] idx_t;
    win   = owner;
    idx   = 0;
    idx_t = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx   = (int'(owner) + k) % N_REQ;
      idx_t = OW'(idx);
      if (pending[idx_t]) win = idx_t;
    end
  end

  assign win_oh   = N_REQ'(1) << win;
  assign clr      = (state == S_IDLE && |pending) ? win_oh : '0;
  assign pend_nxt = (pending & ~clr) | rq_fall;
  assign tick     = (cnt == TMAX);

  // Scheduler state, prescaler, LED counter and grant registers
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pending <= '0;
      led     <= '0;
      grant   <= '0;
      owner   <= OWN0;
`ifdef RUN_ABORT_EN
      ab_flag <= 1'b0;
`endif
    end else begin
      pending <= pend_nxt;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (|pending) begin
            state <= S_RUN;
            grant <= win_oh;
            owner <= win;
            led   <= '0;
          end
        end
        S_RUN: begin
`ifdef RUN_ABORT_EN
          if (ab_fall) begin
            state   <= S_DONE;
            led     <= '0;
            grant   <= '0;
            cnt     <= '0;
            ab_flag <= 1'b1;
          end else
`endif
          if (tick) begin
            cnt <= '0;
            if (led == LMAX) begin
              state <= S_DONE;
              led   <= '0;
              grant <= '0;
            end else begin
              led <= led + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (tick) begin
            state <= S_IDLE;
            cnt   <= '0;
`ifdef RUN_ABORT_EN
            ab_flag <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          led   <= '0;
          grant <= '0;
          cnt   <= '0;
`ifdef RUN_ABORT_EN
          ab_flag <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done_sig = (state == S_DONE);

endmodule

// File: tb/tb_count_run_scheduler.sv
// tb_count_run_scheduler: vector table plus grant-order scoreboard.
// Build with +define+RUN_ABORT_EN to also exercise the abort path.
module tb_count_run_scheduler;

  localparam int NR = 4;
  localparam int TD = 4;
  localparam int MC = 15;
  localparam int RUN_LEN = (MC + 1) * TD;

  logic          clk = 1'b0;
  logic          rst_btn = 1'b0;
  logic [NR-1:0] req_btn = '1;
  logic [3:0]    led;
  logic [NR-1:0] grant;
  logic [1:0]    owner;
  logic          busy;
  logic          done_sig;
`ifdef RUN_ABORT_EN
  logic          abort_btn = 1'b1;
  logic          aborted;
`endif

  count_run_scheduler #(
    .N_REQ(NR), .TICK_DIV(TD), .LED_W(4), .MAX_COUNT(MC)
  ) dut (
    .clk(clk),
    .rst_btn(rst_btn),
    .req_btn(req_btn),
`ifdef RUN_ABORT_EN
    .abort_btn(abort_btn),
    .aborted(aborted),
`endif
    .led(led),
    .grant(grant),
    .owner(owner),
    .busy(busy),
    .done_sig(done_sig)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int done_windows = 0;
  bit skip_len = 0;

  task automatic chk(string nm, int got, int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
    end
  endtask

  // Monitor: pops expected owner at each run start, checks LED stepping,
  // run length and DONE window length.
  bit in_run = 0;
  bit in_done = 0;
  int run_len = 0;
  int done_len = 0;
  int led_bad = 0;
  int e;

  always @(negedge clk) begin
    if (!rst_btn) begin
      in_run = 0;
      in_done = 0;
      run_len = 0;
      done_len = 0;
    end else begin
      if (grant != 0 && !in_run) begin
        in_run = 1;
        run_len = 0;
        led_bad = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_run", int'(owner), -1);
        end else begin
          e = exp_q.pop_front();
          chk("grant_owner", int'(owner), e);
          chk("grant_onehot", int'(grant), 1 << e);
        end
      end
      if (in_run) begin
        if (grant == 0) begin
          in_run = 0;
          if (!skip_len) chk("run_len", run_len, RUN_LEN);
          chk("led_steps", led_bad, 0);
        end else begin
          if (int'(led) != run_len / TD || !busy) led_bad++;
          run_len++;
        end
      end
      if (done_sig) begin
        done_len++;
        in_done = 1;
      end else if (in_done) begin
        chk("done_len", done_len, TD);
        done_windows++;
        in_done = 0;
        done_len = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_btn = 1'b0;
    req_btn = '1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_led", int'(led), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_owner", int'(owner), NR - 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_sig), 0);
    @(negedge clk);
    #1 rst_btn = 1'b1;
  endtask

  task automatic press(logic [NR-1:0] mask, int hold);
    @(negedge clk);
    req_btn = ~mask;
    repeat (hold) @(negedge clk);
    req_btn = '1;
  endtask

  task automatic wait_grant(int who, int lim);
    int n = 0;
    while (grant != NR'(1 << who) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_grant", int'(grant == NR'(1 << who)), 1);
  endtask

  task automatic wait_led(int v, int lim);
    int n = 0;
    while (int'(led) != v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_led", int'(led), v);
  endtask

  task automatic wait_quiet(int lim);
    int q = 0;
    int n = 0;
    while (q < 8 && n < lim) begin
      @(negedge clk);
      n++;
      if (!busy && exp_q.size() == 0) q++;
      else q = 0;
    end
    chk("quiet_reached", int'(q >= 8), 1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  typedef struct packed {
    logic          rst;
    logic [NR-1:0] mask;
    logic [2:0]    n;
    logic [3:0][1:0] ord;
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    int d0;
    int bcnt;

    vecs[0].rst = 1'b1; vecs[0].mask = 4'b0100; vecs[0].n = 3'd1;
    vecs[0].ord = {2'd0, 2'd0, 2'd0, 2'd2};
    vecs[1].rst = 1'b1; vecs[1].mask = 4'b1011; vecs[1].n = 3'd3;
    vecs[1].ord = {2'd0, 2'd3, 2'd1, 2'd0};
    vecs[2].rst = 1'b0; vecs[2].mask = 4'b0011; vecs[2].n = 3'd2;
    vecs[2].ord = {2'd0, 2'd0, 2'd1, 2'd0};
    vecs[3].rst = 1'b0; vecs[3].mask = 4'b1111; vecs[3].n = 3'd4;
    vecs[3].ord = {2'd1, 2'd0, 2'd3, 2'd2};

    do_reset();

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].rst) do_reset();
      d0 = done_windows;
      for (int k = 0; k < int'(vecs[v].n); k++)
        exp_q.push_back(int'(vecs[v].ord[k]));
      press(vecs[v].mask, 10);
      wait_quiet(2000);
      chk("vec_done_windows", done_windows - d0, int'(vecs[v].n));
      chk("vec_idle_led", int'(led), 0);
      chk("vec_idle_grant", int'(grant), 0);
    end

    // Repeated presses by the owner during its run: one extra run
    do_reset();
    d0 = done_windows;
    exp_q.push_back(1);
    press(4'b0010, 4);
    wait_grant(1, 50);
    exp_q.push_back(1);
    for (int k = 0; k < 3; k++) begin
      press(4'b0010, 4);
      repeat (4) @(negedge clk);
    end
    wait_quiet(1000);
    chk("self_repress_runs", done_windows - d0, 2);

    // Owner 1 finishes with 0 and 2 pending: 2 goes before 0
    do_reset();
    exp_q.push_back(1);
    press(4'b0010, 4);
    wait_grant(1, 50);
    exp_q.push_back(2);
    exp_q.push_back(0);
    press(4'b0101, 4);
    wait_quiet(1000);

    // Reset mid-run at led=7 with another request pending
    do_reset();
    exp_q.push_back(2);
    press(4'b0100, 4);
    wait_grant(2, 50);
    press(4'b0001, 4);
    wait_led(7, 100);
    #2 rst_btn = 1'b0;
    #1;
    chk("async_led", int'(led), 0);
    chk("async_grant", int'(grant), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done_sig), 0);
    chk("async_owner", int'(owner), NR - 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_btn = 1'b1;
    bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("no_run_after_reset", bcnt, 0);

`ifdef RUN_ABORT_EN
    do_reset();
    skip_len = 1;
    exp_q.push_back(0);
    press(4'b0001, 4);
    wait_grant(0, 50);
    wait_led(5, 100);
    abort_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_led", int'(led), 0);
    chk("abort_grant", int'(grant), 0);
    chk("abort_done", int'(done_sig), 1);
    chk("abort_flag", int'(aborted), 1);
    abort_btn = 1'b1;
    bcnt = 0;
    @(negedge clk);
    while (done_sig && bcnt < 20) begin
      if (aborted) bcnt++;
      @(negedge clk);
    end
    chk("abort_done_len", bcnt, TD);
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_flag_clear", int'(aborted), 0);
    skip_len = 0;
    @(negedge clk);
    abort_btn = 1'b0;
    repeat (4) @(negedge clk);
    abort_btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_idle_ignored", int'(busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
